// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the memory port arbiter.
// States, requester ids, byte-lane word and latency limit.
package mem_arb_pkg;

  localparam int MEM_LAT_MAX = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_e;

  typedef logic [0:3][7:0] lanes_t;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// arb_pick: combinational winner select for fetch/data ports.
// RR_EN=0 is fixed data-over-fetch; RR_EN=1 follows ptr.
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter bit RR_EN = 1'b0
) (
  input  logic if_req,
  input  logic d_req,
  input  logic ptr,
  output logic gnt_vld,
  output logic gnt_id
);

  logic prefer;

  // Pick the single winner among the pending requests.
  always_comb begin
    prefer  = RR_EN ? ptr : REQ_D;
    gnt_vld = if_req | d_req;
    gnt_id  = REQ_D;
    unique case (1'b1)
      (d_req && !if_req): gnt_id = REQ_D;
      (if_req && !d_req): gnt_id = REQ_IF;
      (if_req && d_req):  gnt_id = prefer;
      default:            gnt_id = REQ_D;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one shared memory port, fetch and data clients.
// Define MEM_ARB_RR_EN for round-robin on contention.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             if_req,
  input  logic [31:0]      if_addr,
  output logic             if_ack,
  output logic [31:0]      if_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [31:0]      d_addr,
  input  logic [0:3][7:0]  d_wdata,
  output logic             d_ack,
  output logic [0:3][7:0]  d_rdata,
  output logic [31:0]      mem_addr,
  output logic [0:3][7:0]  mem_data_in,
  input  logic [0:3][7:0]  mem_data_out,
  output logic             mem_write_en,
  input  logic             halt_req,
  output logic             idle
);

  localparam logic [2:0] LAT = 3'(MEM_LATENCY);

`ifdef MEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  state_e      state;
  logic [2:0]  cnt;
  logic        gnt_id;
  logic [31:0] addr_q;
  logic        we_q;
  lanes_t      wdata_q;
  logic        ptr;
  logic        pick_vld;
  logic        pick_id;
  logic        grant;
  logic        last_acc;

  arb_pick #(
    .RR_EN(RR_EN)
  ) u_pick (
    .if_req (if_req),
    .d_req  (d_req),
    .ptr    (ptr),
    .gnt_vld(pick_vld),
    .gnt_id (pick_id)
  );

  assign grant    = (state == IDLE) && pick_vld && !halt_req;
  assign last_acc = (state == ACCESS) && (cnt == 3'd1);

`ifdef MEM_ARB_RR_EN
  // Favour the other requester after every grant.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)
      ptr <= REQ_D;
    else if (grant)
      ptr <= ~pick_id;
  end
`else
  assign ptr = REQ_D;
`endif

  // Sequencer: latch the winner, count latency, respond.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      gnt_id  <= REQ_D;
      addr_q  <= 32'd0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant) begin
            state  <= ACCESS;
            cnt    <= LAT;
            gnt_id <= pick_id;
            if (pick_id == REQ_D) begin
              addr_q  <= d_addr;
              we_q    <= d_we;
              wdata_q <= d_we ? d_wdata : '0;
            end else begin
              addr_q  <= if_addr;
              we_q    <= 1'b0;
              wdata_q <= '0;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1)
            state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Capture read data into the granted port on the last access edge.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      if_rdata <= 32'd0;
      d_rdata  <= '0;
    end else if (last_acc && !we_q) begin
      if (gnt_id == REQ_IF)
        if_rdata <= mem_data_out;
      else
        d_rdata  <= mem_data_out;
    end
  end

  assign idle   = (state == IDLE);
  assign if_ack = (state == RESP) && (gnt_id == REQ_IF);
  assign d_ack  = (state == RESP) && (gnt_id == REQ_D);

  assign mem_addr     = (state == ACCESS) ? (addr_q & ~32'h3) : 32'd0;
  assign mem_data_in  = (state == ACCESS) ? wdata_q : '0;
  assign mem_write_en = (state == ACCESS) && we_q && (cnt == LAT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench, three latency builds.
// Shared stimulus; each test observes one instance.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_b = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'd0;
  logic [31:0] d_wdata = 32'd0;
  logic [31:0] mem_rd = 32'd0;
  logic        halt_req = 1'b0;

  logic        if_ack1, d_ack1, we1, idle1;
  logic [31:0] if_rd1, d_rd1, maddr1, mdin1;
  logic        if_ack3, d_ack3, we3, idle3;
  logic [31:0] if_rd3, d_rd3, maddr3, mdin3;
  logic        if_ack7, d_ack7, we7, idle7;
  logic [31:0] if_rd7, d_rd7, maddr7, mdin7;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LATENCY(1)) u1 (
    .clk(clk), .rst_b(rst_b),
    .if_req(if_req), .if_addr(if_addr),
    .if_ack(if_ack1), .if_rdata(if_rd1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack1), .d_rdata(d_rd1),
    .mem_addr(maddr1), .mem_data_in(mdin1),
    .mem_data_out(mem_rd), .mem_write_en(we1),
    .halt_req(halt_req), .idle(idle1)
  );

  mem_port_arbiter #(.MEM_LATENCY(3)) u3 (
    .clk(clk), .rst_b(rst_b),
    .if_req(if_req), .if_addr(if_addr),
    .if_ack(if_ack3), .if_rdata(if_rd3),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack3), .d_rdata(d_rd3),
    .mem_addr(maddr3), .mem_data_in(mdin3),
    .mem_data_out(mem_rd), .mem_write_en(we3),
    .halt_req(halt_req), .idle(idle3)
  );

  mem_port_arbiter #(.MEM_LATENCY(7)) u7 (
    .clk(clk), .rst_b(rst_b),
    .if_req(if_req), .if_addr(if_addr),
    .if_ack(if_ack7), .if_rdata(if_rd7),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack7), .d_rdata(d_rd7),
    .mem_addr(maddr7), .mem_data_in(mdin7),
    .mem_data_out(mem_rd), .mem_write_en(we7),
    .halt_req(halt_req), .idle(idle7)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    if_req = 0; d_req = 0; d_we = 0; halt_req = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; mem_rd = 0;
    rst_b = 0;
    tick();
    tick();
    rst_b = 1;
    tick();
  endtask

  task automatic test_reset();
    #1 rst_b = 0;
    #2;
    n_chk++; if (idle1 !== 1'b1) begin n_fail++; $display("FAIL rst_idle got=%b exp=1", idle1); end
    n_chk++; if ({if_ack1, d_ack1} !== 2'b00) begin n_fail++; $display("FAIL rst_acks got=%b exp=00", {if_ack1, d_ack1}); end
    n_chk++; if (if_rd1 !== 32'd0) begin n_fail++; $display("FAIL rst_if_rdata got=%h exp=0", if_rd1); end
    n_chk++; if (d_rd1 !== 32'd0) begin n_fail++; $display("FAIL rst_d_rdata got=%h exp=0", d_rd1); end
    n_chk++; if (maddr1 !== 32'd0) begin n_fail++; $display("FAIL rst_mem_addr got=%h exp=0", maddr1); end
    n_chk++; if (we1 !== 1'b0) begin n_fail++; $display("FAIL rst_we got=%b exp=0", we1); end
    n_chk++; if (mdin1 !== 32'd0) begin n_fail++; $display("FAIL rst_mdin got=%h exp=0", mdin1); end
    n_chk++; if (idle7 !== 1'b1) begin n_fail++; $display("FAIL rst_idle7 got=%b exp=1", idle7); end
  endtask

  task automatic test_fetch();
    do_reset();
    if_req = 1; if_addr = 32'h10; mem_rd = 32'hDEADBEEF;
    tick();
    n_chk++; if (maddr1 !== 32'h10) begin n_fail++; $display("FAIL fetch_addr got=%h exp=10", maddr1); end
    n_chk++; if (if_ack1 !== 1'b0) begin n_fail++; $display("FAIL fetch_early_ack got=%b exp=0", if_ack1); end
    n_chk++; if (idle1 !== 1'b0) begin n_fail++; $display("FAIL fetch_busy got=%b exp=0", idle1); end
    tick();
    n_chk++; if (if_ack1 !== 1'b1) begin n_fail++; $display("FAIL fetch_ack got=%b exp=1", if_ack1); end
    n_chk++; if (if_rd1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fetch_data got=%h exp=deadbeef", if_rd1); end
    n_chk++; if (maddr1 !== 32'd0) begin n_fail++; $display("FAIL fetch_addr_resp got=%h exp=0", maddr1); end
    if_req = 0;
    tick();
    n_chk++; if (if_ack1 !== 1'b0) begin n_fail++; $display("FAIL fetch_ack_pulse got=%b exp=0", if_ack1); end
    n_chk++; if (idle1 !== 1'b1) begin n_fail++; $display("FAIL fetch_idle got=%b exp=1", idle1); end
    mem_rd = 32'h0;
    tick();
    n_chk++; if (if_rd1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fetch_hold got=%h exp=deadbeef", if_rd1); end
  endtask

  task automatic test_store();
    do_reset();
    mem_rd = 32'hCAFEF00D;
    d_req = 1; d_we = 1; d_addr = 32'h23; d_wdata = 32'h11223344;
    tick();
    n_chk++; if (maddr1 !== 32'h20) begin n_fail++; $display("FAIL st_addr got=%h exp=20", maddr1); end
    n_chk++; if (we1 !== 1'b1) begin n_fail++; $display("FAIL st_we got=%b exp=1", we1); end
    n_chk++; if (mdin1 !== 32'h11223344) begin n_fail++; $display("FAIL st_lanes got=%h exp=11223344", mdin1); end
    tick();
    n_chk++; if (d_ack1 !== 1'b1) begin n_fail++; $display("FAIL st_ack got=%b exp=1", d_ack1); end
    n_chk++; if (we1 !== 1'b0) begin n_fail++; $display("FAIL st_we_resp got=%b exp=0", we1); end
    n_chk++; if (mdin1 !== 32'd0) begin n_fail++; $display("FAIL st_mdin_resp got=%h exp=0", mdin1); end
    n_chk++; if (d_rd1 !== 32'd0) begin n_fail++; $display("FAIL st_rdata got=%h exp=0", d_rd1); end
    d_req = 0; d_we = 0;
    tick();
    n_chk++; if (d_ack1 !== 1'b0) begin n_fail++; $display("FAIL st_ack_pulse got=%b exp=0", d_ack1); end
  endtask

  task automatic test_contention();
    logic exp_d [4];
    int c;
    logic rr;
`ifdef MEM_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    exp_d[0] = 1'b1;
    exp_d[1] = !rr;
    exp_d[2] = 1'b1;
    exp_d[3] = !rr;
    do_reset();
    mem_rd = 32'hA5A50001;
    d_we = 0; d_addr = 32'h80; if_addr = 32'h100;
    if_req = 1; d_req = 1;
    for (int k = 0; k < 4; k++) begin
      c = 0;
      while (!(if_ack1 || d_ack1) && c < 10) begin
        tick();
        c++;
      end
      n_chk++;
      if (!(if_ack1 || d_ack1)) begin
        n_fail++; $display("FAIL arb_timeout access=%0d", k);
      end else begin
        if (d_ack1 !== exp_d[k] || if_ack1 !== !exp_d[k]) begin
          n_fail++; $display("FAIL arb_order access=%0d d_ack=%b if_ack=%b exp_d=%b", k, d_ack1, if_ack1, exp_d[k]);
        end
        n_chk++; if (c != 2) begin n_fail++; $display("FAIL arb_spacing access=%0d got=%0d exp=2", k, c); end
      end
      tick();
    end
    if_req = 0; d_req = 0;
    n_chk++; if (d_rd1 !== 32'hA5A50001) begin n_fail++; $display("FAIL arb_d_rdata got=%h exp=a5a50001", d_rd1); end
    n_chk++; if (if_rd1 !== (rr ? 32'hA5A50001 : 32'd0)) begin n_fail++; $display("FAIL arb_if_rdata got=%h rr=%b", if_rd1, rr); end
    tick();
    tick();
  endtask

  task automatic test_halt();
    do_reset();
    d_req = 1; d_we = 0; d_addr = 32'h44; mem_rd = 32'h5555AAAA;
    tick();
    halt_req = 1; if_req = 1; if_addr = 32'h200;
    n_chk++; if (maddr1 !== 32'h44) begin n_fail++; $display("FAIL halt_access_addr got=%h exp=44", maddr1); end
    tick();
    n_chk++; if (d_ack1 !== 1'b1) begin n_fail++; $display("FAIL halt_ack got=%b exp=1", d_ack1); end
    n_chk++; if (d_rd1 !== 32'h5555AAAA) begin n_fail++; $display("FAIL halt_rdata got=%h exp=5555aaaa", d_rd1); end
    d_req = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (idle1 !== 1'b1 || maddr1 !== 32'd0 || if_ack1 !== 1'b0) begin
        n_fail++; $display("FAIL halt_hold cyc=%0d idle=%b addr=%h if_ack=%b exp idle=1 addr=0 ack=0", i, idle1, maddr1, if_ack1);
      end
    end
    halt_req = 0;
    tick();
    n_chk++; if (maddr1 !== 32'h200 || idle1 !== 1'b0) begin n_fail++; $display("FAIL halt_resume addr=%h idle=%b exp addr=200 idle=0", maddr1, idle1); end
    tick();
    n_chk++; if (if_ack1 !== 1'b1) begin n_fail++; $display("FAIL halt_resume_ack got=%b exp=1", if_ack1); end
    if_req = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h55667788;
    tick();
    n_chk++; if (we3 !== 1'b1 || maddr3 !== 32'h40) begin n_fail++; $display("FAIL rmid_first we=%b addr=%h exp we=1 addr=40", we3, maddr3); end
    tick();
    n_chk++; if (we3 !== 1'b0 || maddr3 !== 32'h40) begin n_fail++; $display("FAIL rmid_second we=%b addr=%h exp we=0 addr=40", we3, maddr3); end
    #2 rst_b = 0;
    #1;
    n_chk++;
    if (we3 !== 1'b0 || maddr3 !== 32'd0 || idle3 !== 1'b1 || d_ack3 !== 1'b0 || mdin3 !== 32'd0) begin
      n_fail++; $display("FAIL rmid_now we=%b addr=%h idle=%b ack=%b mdin=%h", we3, maddr3, idle3, d_ack3, mdin3);
    end
    d_req = 0; d_we = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) rst_b = 1;
      tick();
      n_chk++;
      if (d_ack3 !== 1'b0 || we3 !== 1'b0) begin
        n_fail++; $display("FAIL rmid_after cyc=%0d ack=%b we=%b exp 0 0", i, d_ack3, we3);
      end
    end
  endtask

  task automatic test_lat7();
    do_reset();
    if_req = 1; if_addr = 32'h104; mem_rd = 32'h01234567;
    tick();
    for (int i = 1; i <= 7; i++) begin
      n_chk++;
      if (maddr7 !== 32'h104 || if_ack7 !== 1'b0) begin
        n_fail++; $display("FAIL lat7_hold cyc=%0d addr=%h ack=%b exp addr=104 ack=0", i, maddr7, if_ack7);
      end
      tick();
    end
    n_chk++; if (if_ack7 !== 1'b1) begin n_fail++; $display("FAIL lat7_ack got=%b exp=1", if_ack7); end
    n_chk++; if (if_rd7 !== 32'h01234567) begin n_fail++; $display("FAIL lat7_data got=%h exp=01234567", if_rd7); end
    n_chk++; if (maddr7 !== 32'd0) begin n_fail++; $display("FAIL lat7_addr_resp got=%h exp=0", maddr7); end
    if_req = 0;
    tick();
    n_chk++; if (if_ack7 !== 1'b0) begin n_fail++; $display("FAIL lat7_pulse got=%b exp=0", if_ack7); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_contention();
    test_halt();
    test_reset_mid();
    test_lat7();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
